// File: rtl/vga_fb_arbiter_pkg.sv
// vga_fb_arbiter_pkg
// Shared display timing constants, arbiter state type and small helpers used
// by the framebuffer arbiter. No ports; import with vga_fb_arbiter_pkg::*.
package vga_fb_arbiter_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_TOTAL   = 800;
    localparam int V_VISIBLE = 480;
    localparam int V_TOTAL   = 525;
    // Writes must stop this many columns before the next visible pixel so the
    // last WRITE is followed by TURN before the first READ.
    localparam int WR_GUARD  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_TURN  = 2'd3
    } arb_state_e;

    // row*640 + col as two shifts and an add; 20 bits covers any 10-bit row/col.
    function automatic logic [19:0] pix_addr(input logic [9:0] row, input logic [9:0] col);
        return ({10'd0, row} << 9) + ({10'd0, row} << 7) + {10'd0, col};
    endfunction

    // True when a write issued next cycle still leaves room for TURN before
    // the next visible pixel.
    function automatic logic wr_window(input logic [9:0] row, input logic [9:0] col);
        logic ok;
        if (row < 10'(V_VISIBLE))
            ok = (col >= 10'(H_VISIBLE)) && (col < 10'(H_TOTAL - WR_GUARD));
        else
            ok = !((row == 10'(V_TOTAL - 1)) && (col >= 10'(H_TOTAL - WR_GUARD)));
        return ok;
    endfunction

endpackage

// File: rtl/vga_fb_arbiter_sync_fifo.sv
// sync_fifo
// Single-clock FIFO with full/empty flags. Push is ignored when full, pop is
// ignored when empty. Reset discards contents by clearing pointers/count.
// Ports: clk_i, reset_ni (async low), push_i/data_i, pop_i/data_o (head),
//        full_o, empty_o. DEPTH must be a power of 2, at least 2.
module sync_fifo #(
    parameter int WIDTH = 31,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rptr_q];

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Shares one async SRAM between display reads (always win while visible) and
// buffered host writes drained in blanking, with a TURN cycle after the last
// write. Emits pixel data with visible/hsync/vsync delayed 2 cycles.
// Ports: clk_i, reset_ni (async low); vga_* timing inputs; wr_valid_i/
//        wr_ready_o/wr_addr_i/wr_data_i host writes; sram_* bus (registered);
//        pix_* aligned pixel stream.
module vga_fb_arbiter
    import vga_fb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  vga_visible_i,
    input  logic                  vga_hsync_i,
    input  logic                  vga_vsync_i,
    input  logic [9:0]            vga_column_i,
    input  logic [9:0]            vga_row_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_data_o,
    input  logic [DATA_WIDTH-1:0] sram_data_i,
    output logic                  sram_we_n_o,
    output logic                  sram_oe_n_o,
    output logic                  sram_data_oe_o,
    output logic                  pix_visible_o,
    output logic                  pix_hsync_o,
    output logic                  pix_vsync_o,
    output logic [DATA_WIDTH-1:0] pix_data_o
);
    localparam int FW = ADDR_WIDTH + DATA_WIDTH;

    arb_state_e            state_q, state_d;
    logic                  fifo_full, fifo_empty;
    logic [FW-1:0]         fifo_head;
    logic [ADDR_WIDTH-1:0] head_addr, disp_addr, sram_addr_q;
    logic [DATA_WIDTH-1:0] head_data, sram_data_q, pix_data_q;
    logic                  we_n_q, oe_n_q, data_oe_q;
    logic [1:0]            vis_pipe_q, hs_pipe_q, vs_pipe_q;

    assign wr_ready_o = !fifo_full;
    assign {head_addr, head_data} = fifo_head;
    assign disp_addr = ADDR_WIDTH'(pix_addr(vga_row_i, vga_column_i));

    sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .push_i  (wr_valid_i && wr_ready_o),
        .data_i  ({wr_addr_i, wr_data_i}),
        .pop_i   (state_d == ST_WRITE),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d = ST_IDLE;
        if (vga_visible_i)
            state_d = ST_READ;
        else if (!fifo_empty && wr_window(vga_row_i, vga_column_i))
            state_d = ST_WRITE;
        else if (state_q == ST_WRITE)
            state_d = ST_TURN;
    end

    // Bus strobes are registered from the next state so the SRAM sees a clean
    // cycle-aligned address/strobe pair.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ST_IDLE;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            data_oe_q   <= 1'b0;
            sram_addr_q <= '0;
            sram_data_q <= '0;
            pix_data_q  <= '0;
            vis_pipe_q  <= 2'b00;
            hs_pipe_q   <= 2'b11;
            vs_pipe_q   <= 2'b11;
        end else begin
            state_q   <= state_d;
            we_n_q    <= (state_d != ST_WRITE);
            oe_n_q    <= (state_d != ST_READ);
            data_oe_q <= (state_d == ST_WRITE);
            if (state_d == ST_READ) begin
                sram_addr_q <= disp_addr;
            end else if (state_d == ST_WRITE) begin
                sram_addr_q <= head_addr;
                sram_data_q <= head_data;
            end
            vis_pipe_q <= {vis_pipe_q[0], vga_visible_i};
            hs_pipe_q  <= {hs_pipe_q[0],  vga_hsync_i};
            vs_pipe_q  <= {vs_pipe_q[0],  vga_vsync_i};
            // vis_pipe_q[0] marks the cycle whose READ is on the bus now.
            pix_data_q <= vis_pipe_q[0] ? sram_data_i : '0;
        end
    end

    assign sram_addr_o    = sram_addr_q;
    assign sram_data_o    = sram_data_q;
    assign sram_we_n_o    = we_n_q;
    assign sram_oe_n_o    = oe_n_q;
    assign sram_data_oe_o = data_oe_q;
    assign pix_visible_o  = vis_pipe_q[1];
    assign pix_hsync_o    = hs_pipe_q[1];
    assign pix_vsync_o    = vs_pipe_q[1];
    assign pix_data_o     = pix_data_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter
// Drives a settable display position plus host writes, models the SRAM, and
// compares the DUT against a frame-level reference: pixel = framebuffer at
// (row*640+col) two cycles later, writes land in order during blanking.
module tb_vga_fb_arbiter;
    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        vga_visible_i, vga_hsync_i, vga_vsync_i;
    logic [9:0]  vga_column_i, vga_row_i;
    logic        wr_valid_i, wr_ready_o;
    logic [18:0] wr_addr_i;
    logic [11:0] wr_data_i;
    logic [18:0] sram_addr_o;
    logic [11:0] sram_data_o, sram_data_i;
    logic        sram_we_n_o, sram_oe_n_o, sram_data_oe_o;
    logic        pix_visible_o, pix_hsync_o, pix_vsync_o;
    logic [11:0] pix_data_o;

    always #5 clk_i = ~clk_i;

    vga_fb_arbiter dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .vga_visible_i(vga_visible_i), .vga_hsync_i(vga_hsync_i), .vga_vsync_i(vga_vsync_i),
        .vga_column_i(vga_column_i), .vga_row_i(vga_row_i),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .sram_addr_o(sram_addr_o), .sram_data_o(sram_data_o), .sram_data_i(sram_data_i),
        .sram_we_n_o(sram_we_n_o), .sram_oe_n_o(sram_oe_n_o), .sram_data_oe_o(sram_data_oe_o),
        .pix_visible_o(pix_visible_o), .pix_hsync_o(pix_hsync_o), .pix_vsync_o(pix_vsync_o),
        .pix_data_o(pix_data_o)
    );

    // SRAM: async read while OE low, write on the clock edge ending a WE cycle.
    bit [11:0] mem    [0:524287];
    bit [11:0] refmem [0:524287];
    assign sram_data_i = !sram_oe_n_o ? mem[sram_addr_o] : 12'd0;
    always @(posedge clk_i) if (!sram_we_n_o && sram_data_oe_o) mem[sram_addr_o] <= sram_data_o;

    typedef struct { int addr; int data; bit upd; } wr_t;
    wr_t wq[$];    // accepted, not yet seen on the bus
    wr_t pend[$];  // accepted, not yet folded into refmem

    int n_chk = 0, n_pass = 0;
    int col, row, frame, cyc, r0;
    int jr = -1, jc = 0;
    bit rdy, acc, saw_we, watch_we;
    int acc_col;
    int h_col[4], h_row[4], h_pix[4];
    bit h_vis[4], h_hs[4], h_vs[4], h_we[4];
    wr_t cur;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (row %0d col %0d)", tag, got, exp, row, col);
    endtask

    function automatic bit f_vis(int c, int r); return c < 640 && r < 480; endfunction
    function automatic bit f_hs(int c);  return !(c >= 656 && c < 752); endfunction
    function automatic bit f_vs(int r);  return !(r >= 490 && r < 492); endfunction
    function automatic bit f_win(int c, int r);
        return (r < 480) ? (c >= 640 && c < 797) : !(r == 524 && c >= 797);
    endfunction

    task automatic drive();
        int k;
        // Every write accepted before a blanking interval is in the framebuffer after it.
        if (!f_vis(col, row))
            while (pend.size() > 0) begin
                wr_t w;
                w = pend.pop_front();
                refmem[w.addr] = 12'(w.data);
            end
        vga_column_i  = 10'(col);
        vga_row_i     = 10'(row);
        vga_visible_i = f_vis(col, row);
        vga_hsync_i   = f_hs(col);
        vga_vsync_i   = f_vs(row);
        k = cyc & 3;
        h_col[k] = col; h_row[k] = row;
        h_vis[k] = f_vis(col, row); h_hs[k] = f_hs(col); h_vs[k] = f_vs(row);
        h_pix[k] = f_vis(col, row) ? int'(refmem[row*640 + col]) : 0;
    endtask

    task automatic advance();
        if (jr >= 0) begin
            row = jr; col = jc; jr = -1;
        end else begin
            col++;
            if (col == 800) begin
                col = 0; row++;
                if (row == 525) begin row = 0; frame++; end
            end
        end
    endtask

    task automatic set_wr(input int a, input int d, input bit upd);
        cur.addr = a; cur.data = d; cur.upd = upd;
        wr_addr_i = 19'(a); wr_data_i = 12'(d);
    endtask

    // One cycle: check at negedge, accept at posedge, drive next inputs.
    task automatic step();
        int k, p1, p2, since;
        @(negedge clk_i);
        k = cyc & 3; p1 = (cyc - 1) & 3; p2 = (cyc - 2) & 3; since = cyc - r0;
        chk("we_oe_excl", sram_we_n_o | sram_oe_n_o, 1);
        if (sram_data_oe_o) chk("doe_needs_oe_high", sram_oe_n_o, 1);
        if (since >= 1) begin
            chk("oe_follows_vis", !sram_oe_n_o, h_vis[p1]);
            if (!sram_oe_n_o) chk("rd_addr", sram_addr_o, h_row[p1]*640 + h_col[p1]);
            if (!sram_we_n_o) begin
                saw_we = 1;
                chk("wr_window", f_win(h_col[p1], h_row[p1]) && !h_vis[p1], 1);
                if (wq.size() == 0) chk("wr_spurious", 0, 1);
                else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("wr_addr", sram_addr_o, w.addr);
                    chk("wr_data", sram_data_o, w.data);
                end
            end
        end
        if (since >= 2) begin
            chk("pix_vis", pix_visible_o, h_vis[p2]);
            chk("pix_hs", pix_hsync_o, h_hs[p2]);
            chk("pix_vs", pix_vsync_o, h_vs[p2]);
            chk("pix_data", pix_data_o, h_pix[p2]);
            if (!sram_oe_n_o) chk("guard_rd_after_wr", h_we[p1] & h_we[p2], 1);
            if (frame == 0 && h_row[p2] == 2 && h_col[p2] == 5) chk("px_r2c5", pix_data_o, 1285);
            if (frame == 1 && h_row[p2] == 0 && h_col[p2] == 100) chk("abc_readback", pix_data_o, 'hABC);
        end
        h_we[k] = sram_we_n_o;
        chk("wr_ready", wr_ready_o, wq.size() < 4);
        if (watch_we && !sram_we_n_o) begin
            chk("wr_issue_col", col == 640 || col == 641, 1);
            watch_we = 0;
        end
        if (frame == 0 && row == 1 && col == 100) chk("full_ready_low", wr_ready_o, 0);
        if (frame == 0 && row == 2 && col == 797) chk("bnd797_we", sram_we_n_o, 0);
        if (frame == 0 && row == 2 && col == 798) chk("bnd798_we", sram_we_n_o, 1);
        rdy = wr_ready_o;
        @(posedge clk_i);
        acc = wr_valid_i && rdy;
        if (acc) begin
            wq.push_back(cur);
            if (cur.upd) pend.push_back(cur);
            acc_col = col;
        end
        #1;
        cyc++;
        advance();
        drive();
    endtask

    task automatic run_until(input int r, input int c);
        int n = 0;
        while (!(row == r && col == c)) begin
            step();
            n++;
            if (n > 60000) begin chk("run_until_timeout", n, 0); break; end
        end
    endtask

    initial begin
        int n_acc, acc5, n;
        for (int i = 0; i < 524288; i++) begin
            mem[i] = 12'(i); refmem[i] = 12'(i);
        end
        reset_ni = 0; wr_valid_i = 0; set_wr(0, 0, 0);
        col = 0; row = 0; frame = 0; cyc = 0; r0 = 0;
        drive();
        repeat (3) begin
            @(negedge clk_i);
            chk("rst_pix_vis", pix_visible_o, 0);
            chk("rst_pix_hs", pix_hsync_o, 1);
            chk("rst_pix_vs", pix_vsync_o, 1);
            chk("rst_pix_data", pix_data_o, 0);
            chk("rst_we_n", sram_we_n_o, 1);
            chk("rst_oe_n", sram_oe_n_o, 1);
            chk("rst_data_oe", sram_data_oe_o, 0);
            chk("rst_addr", sram_addr_o, 0);
        end
        @(posedge clk_i); #1;
        reset_ni = 1; r0 = cyc;
        chk("rdy_after_rst", wr_ready_o, 1);

        // Single write during visible: must wait for horizontal blanking.
        run_until(0, 10);
        set_wr(100, 'hABC, 1); wr_valid_i = 1; step(); wr_valid_i = 0;
        chk("abc_accepted", acc, 1);
        watch_we = 1;

        // Five back-to-back writes while visible: fourth fills the FIFO.
        run_until(1, 20);
        n_acc = 0; acc5 = -1; n = 0;
        while (n_acc < 5 && n < 2000) begin
            set_wr(6400 + n_acc*7, $urandom_range(4095), 1);
            wr_valid_i = 1; step(); n++;
            if (acc) begin n_acc++; if (n_acc == 5) acc5 = acc_col; end
        end
        wr_valid_i = 0;
        chk("acc5_col", acc5, 641);

        // Guard boundary: pushed at 795 issues at 797; pushed at 796 must wait.
        run_until(2, 795);
        set_wr(6500, $urandom_range(4095), 1); wr_valid_i = 1; step();
        chk("bnd_acc795", acc, 1);
        set_wr(6501, $urandom_range(4095), 1); step(); wr_valid_i = 0;
        chk("bnd_acc796", acc, 1);

        // Random writes across vertical blanking and into the next frame.
        run_until(3, 799);
        jr = 522; jc = 0; step();
        n = 0;
        while (!(frame == 1 && row == 3 && col == 799) && n < 20000) begin
            wr_valid_i = (frame == 0 || row < 3) && ($urandom_range(2) == 0);
            if (wr_valid_i) set_wr(6400 + $urandom_range(6399), $urandom_range(4095), 1);
            step(); n++;
        end
        wr_valid_i = 0;

        // Display the randomly written rows.
        jr = 10; jc = 0; step();
        run_until(19, 799);

        // Reset in the middle of a blanking write burst.
        jr = 480; jc = 0; step();
        set_wr(300800, 'h111, 0); wr_valid_i = 1; step();
        set_wr(300801, 'h222, 0); step(); wr_valid_i = 0;
        saw_we = 0; n = 0;
        while (!saw_we && n < 10) begin step(); n++; end
        chk("pre_rst_we", sram_we_n_o, 0);
        #1 reset_ni = 0;
        #1;
        chk("arst_we_n", sram_we_n_o, 1);
        chk("arst_data_oe", sram_data_oe_o, 0);
        chk("arst_oe_n", sram_oe_n_o, 1);
        chk("arst_addr", sram_addr_o, 0);
        wq.delete(); pend.delete();
        repeat (2) begin @(posedge clk_i); #1; cyc++; advance(); drive(); end
        reset_ni = 1; r0 = cyc;
        chk("rdy_after_rst2", wr_ready_o, 1);
        saw_we = 0;
        repeat (30) step();
        chk("fifo_empty_after_rst", saw_we, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
